sensor_sync_decoder: RTL and testbench
======================================

Name: sensor_sync_decoder

Overview:
Front-end stage that turns raw parallel camera pins (vsync, href, 8-bit data on pixclk) into the framing/strobe interface consumed by the image buffer controller: sensor_din, sensor_state, frame_begin, line_begin, frame_state and line_state. It registers the pins, detects sync edges, and aligns capture to whole frames. It also counts pixels, lines and frames and flags geometry errors against the expected sensor resolution.

Parameters:
VSYNC_POL, 1, active level of cam_vsync (1 = high during vertical blanking pulse)
HREF_POL, 1, active level of cam_href (1 = high while line pixels are valid)
LINE_PIXELS, 640, expected bytes per line
FRAME_LINES, 480, expected lines per frame

Ports:
pixclk  in  1  pixel clock; sole clock domain
reset  in  1  asynchronous, active-high reset
enable  in  1  capture enable; sampled at frame boundaries only
cam_vsync  in  1  raw sensor vsync
cam_href  in  1  raw sensor href
cam_data  in  8  raw sensor pixel byte
sensor_din  out  8  registered pixel byte
sensor_state  out  1  sensor_din valid this cycle
frame_begin  out  1  one-cycle pulse at start of captured frame
line_begin  out  1  one-cycle pulse coincident with first byte of each line
frame_state  out  1  high for the whole captured frame
line_state  out  1  high while the current line is being delivered
pixel_count  out  12  bytes delivered so far in the current line
line_count  out  12  lines completed in the current frame
frame_count  out  16  frames completed since reset, wraps modulo 2^16
line_err  out  1  sticky: a line length differed from LINE_PIXELS
frame_err  out  1  sticky: a frame line count differed from FRAME_LINES

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM = IDLE; input stage registers cleared to inactive levels.
- Stage 1 registers cam_* every pixclk; vs/hr are the polarity-normalised stage-1 values (1 = active). Edges compare stage 1 with the previous stage-1 value. All outputs are registered, so pin-to-output latency is 2 pixclk.
- FSM states:
  IDLE: if enable=1 -> SYNC.
  SYNC: wait for vs=1 -> ARM. This discards any partial frame.
  ARM: wait for the vs 1->0 edge -> FRAME. In the same cycle, assert frame_begin, set frame_state=1, clear line_count, pixel_count, line_err and frame_err.
  FRAME: on the vs 0->1 edge, frame_state=0. If line_count != FRAME_LINES, set frame_err. frame_count increments. Next state: ARM if enable=1, else IDLE.
- Lines (FRAME only):
  - On the hr 0->1 edge: line_begin=1, line_state=1, sensor_state=1, sensor_din=byte, pixel_count=1.
  - While hr=1: sensor_state=1 each cycle, pixel_count increments and saturates at 4095.
  - On the hr 1->0 edge: line_state=0, sensor_state=0, line_count increments (saturates at 4095). If pixel_count != LINE_PIXELS, set line_err.
- Outside FRAME, sensor_state, line_state and line_begin stay 0. sensor_din holds its last value when not valid.
- Boundary cases:
  - href already active when FRAME is entered: that line is ignored until hr returns to 0. No line_begin is issued, and it is not counted.
  - vs asserted mid-line: line_state and sensor_state drop in the same cycle as frame_state. The truncated line is counted and length-checked, so line_err is set. frame_err is then evaluated using the updated line_count.
  - enable deasserted mid-frame: the current frame completes normally and the FSM returns to IDLE at vs assertion. Deasserting enable in SYNC or ARM returns to IDLE immediately.
  - One-cycle href pulse: line_begin, line_state and sensor_state are high for 1 cycle, pixel_count=1, and the line is counted.
  - frame_begin and line_begin are never asserted in the same cycle, because a line can only start after FRAME is entered.
  - Reset mid-frame: immediate return to IDLE with all outputs 0; frame_count is cleared.

Test Plan:
- Nominal: enable=1, 3 frames of 480 lines x 640 bytes, data = incrementing counter -> sensor_din matches pins delayed 2 cycles; 480 line_begin pulses per frame; frame_count=3; line_err=0, frame_err=0.
- Mid-frame start: enable raised during line 100 of a frame -> no outputs until the next vs pulse completes; the first frame_begin occurs at the following vs deassert.
- Short line: one line of 639 bytes -> line_err=1 from the end of that line; it clears at the next frame_begin only.
- Truncation: vsync asserted at byte 300 of line 200 -> line_state and frame_state fall in the same cycle; line_count=201; line_err=1; frame_err=1.
- Disable mid-frame: enable=0 at line 10 -> the frame finishes with 480 lines; FSM returns to IDLE; no further frame_begin occurs.
- Polarity/reset: VSYNC_POL=0, HREF_POL=0 with inverted stimulus gives results identical to the nominal test. Async reset asserted mid-line -> all outputs 0 within the same cycle, with no pixclk edge required.

Source files
------------

// File: rtl/sensor_sync_decoder.sv
// Camera pin front end: registers raw vsync/href/data, detects sync edges, aligns capture to
// whole frames and produces the framing/strobe interface for the image buffer controller.
// Also counts pixels, lines and frames, and flags geometry errors against the expected size.
module sensor_sync_decoder #(
  parameter bit          VSYNC_POL   = 1'b1,
  parameter bit          HREF_POL    = 1'b1,
  parameter int unsigned LINE_PIXELS = 640,
  parameter int unsigned FRAME_LINES = 480
) (
  input  logic        pixclk,
  input  logic        reset,
  input  logic        enable,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic [7:0]  sensor_din,
  output logic        sensor_state,
  output logic        frame_begin,
  output logic        line_begin,
  output logic        frame_state,
  output logic        line_state,
  output logic [11:0] pixel_count,
  output logic [11:0] line_count,
  output logic [15:0] frame_count,
  output logic        line_err,
  output logic        frame_err
);

  localparam logic [11:0] LinePix   = 12'(LINE_PIXELS);
  localparam logic [11:0] FrameLns  = 12'(FRAME_LINES);
  localparam logic [11:0] CountMax  = 12'hFFF;

  typedef enum logic [1:0] {StIdle, StSync, StArm, StFrame} state_e;

  state_e state_q, state_d;

  // Stage-1 sync values are stored polarity-normalised (1 = active).
  logic       vs_q, vs_prev_q, hr_q, hr_prev_q;
  logic [7:0] data_q;

  logic [7:0]  din_q, din_d;
  logic        sstate_q, sstate_d;
  logic        fb_q, fb_d;
  logic        lb_q, lb_d;
  logic        fs_q, fs_d;
  logic        ls_q, ls_d;
  logic [11:0] pc_q, pc_d;
  logic [11:0] lc_q, lc_d;
  logic [15:0] fc_q, fc_d;
  logic        le_q, le_d;
  logic        fe_q, fe_d;

  logic        vs_rise, vs_fall, hr_rise;
  logic [11:0] pc_inc, lc_inc, lc_end;

  assign vs_rise = vs_q & ~vs_prev_q;
  assign vs_fall = ~vs_q & vs_prev_q;
  assign hr_rise = hr_q & ~hr_prev_q;
  assign pc_inc  = (pc_q == CountMax) ? pc_q : pc_q + 12'd1;
  assign lc_inc  = (lc_q == CountMax) ? lc_q : lc_q + 12'd1;

  // Input stage: register pins and keep the previous stage-1 sync values for edge detection.
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
      hr_q      <= 1'b0;
      hr_prev_q <= 1'b0;
      data_q    <= 8'h00;
    end else begin
      vs_q      <= (cam_vsync == VSYNC_POL);
      vs_prev_q <= vs_q;
      hr_q      <= (cam_href == HREF_POL);
      hr_prev_q <= hr_q;
      data_q    <= cam_data;
    end
  end

  // Frame-alignment FSM state register.
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d  = state_q;
    din_d    = din_q;
    sstate_d = 1'b0;
    fb_d     = 1'b0;
    lb_d     = 1'b0;
    fs_d     = fs_q;
    ls_d     = ls_q;
    pc_d     = pc_q;
    lc_d     = lc_q;
    fc_d     = fc_q;
    le_d     = le_q;
    fe_d     = fe_q;
    lc_end   = lc_q;

    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StSync;
      end
      StSync: begin
        // Waiting for a vsync pulse discards any partially seen frame.
        if (!enable)   state_d = StIdle;
        else if (vs_q) state_d = StArm;
      end
      StArm: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (vs_fall) begin
          state_d = StFrame;
          fb_d    = 1'b1;
          fs_d    = 1'b1;
          lc_d    = 12'd0;
          pc_d    = 12'd0;
          le_d    = 1'b0;
          fe_d    = 1'b0;
        end
      end
      StFrame: begin
        if (vs_rise) begin
          // A line still open at vsync is truncated but counted and length-checked.
          fs_d = 1'b0;
          ls_d = 1'b0;
          if (ls_q) begin
            lc_end = lc_inc;
            if (pc_q != LinePix) le_d = 1'b1;
          end
          lc_d = lc_end;
          if (lc_end != FrameLns) fe_d = 1'b1;
          fc_d    = fc_q + 16'd1;
          state_d = enable ? StArm : StIdle;
        end else if (ls_q) begin
          if (hr_q) begin
            sstate_d = 1'b1;
            din_d    = data_q;
            pc_d     = pc_inc;
          end else begin
            ls_d = 1'b0;
            lc_d = lc_inc;
            if (pc_q != LinePix) le_d = 1'b1;
          end
        end else if (hr_rise) begin
          // Only a rising href starts a line, so one already active at frame entry is ignored.
          lb_d     = 1'b1;
          ls_d     = 1'b1;
          sstate_d = 1'b1;
          din_d    = data_q;
          pc_d     = 12'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      din_q    <= 8'h00;
      sstate_q <= 1'b0;
      fb_q     <= 1'b0;
      lb_q     <= 1'b0;
      fs_q     <= 1'b0;
      ls_q     <= 1'b0;
      pc_q     <= 12'd0;
      lc_q     <= 12'd0;
      fc_q     <= 16'd0;
      le_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      din_q    <= din_d;
      sstate_q <= sstate_d;
      fb_q     <= fb_d;
      lb_q     <= lb_d;
      fs_q     <= fs_d;
      ls_q     <= ls_d;
      pc_q     <= pc_d;
      lc_q     <= lc_d;
      fc_q     <= fc_d;
      le_q     <= le_d;
      fe_q     <= fe_d;
    end
  end

  assign sensor_din   = din_q;
  assign sensor_state = sstate_q;
  assign frame_begin  = fb_q;
  assign line_begin   = lb_q;
  assign frame_state  = fs_q;
  assign line_state   = ls_q;
  assign pixel_count  = pc_q;
  assign line_count   = lc_q;
  assign frame_count  = fc_q;
  assign line_err     = le_q;
  assign frame_err    = fe_q;

endmodule

// File: tb/tb_sensor_sync_decoder.sv
// Bench for sensor_sync_decoder: a cycle-exact vector table, hand-written corner sequences and
// randomised frames checked by a frame-level scoreboard. Runs once on an active-high instance
// and once on an active-low instance fed inverted sync pins.
module tb_sensor_sync_decoder;
  localparam int LP = 6;
  localparam int FL = 4;

  typedef struct packed {
    logic        fs, fb, ls, lb, ss;
    logic [7:0]  din;
    logic [11:0] pc, lc;
    logic        le, fe;
    logic [15:0] fc;
  } out_t;

  typedef struct {
    int v, h, d, fs, fb, ls, lb, ss, din, pc, lc, le, fe, fc;
  } vec_t;

  logic pixclk = 1'b0;
  logic reset, enable, vs_pin, hr_pin, pass_sel;
  logic [7:0] d_pin;

  logic [7:0]  a_din, b_din;
  logic        a_ss, a_fb, a_lb, a_fs, a_ls, a_le, a_fe;
  logic        b_ss, b_fb, b_lb, b_fs, b_ls, b_le, b_fe;
  logic [11:0] a_pc, a_lc, b_pc, b_lc;
  logic [15:0] a_fc, b_fc;
  out_t a_o, b_o, s;

  always #5 pixclk = ~pixclk;

  sensor_sync_decoder #(.VSYNC_POL(1'b1), .HREF_POL(1'b1), .LINE_PIXELS(LP), .FRAME_LINES(FL))
  dut_a (
    .pixclk(pixclk), .reset(reset), .enable(enable), .cam_vsync(vs_pin), .cam_href(hr_pin),
    .cam_data(d_pin), .sensor_din(a_din), .sensor_state(a_ss), .frame_begin(a_fb),
    .line_begin(a_lb), .frame_state(a_fs), .line_state(a_ls), .pixel_count(a_pc),
    .line_count(a_lc), .frame_count(a_fc), .line_err(a_le), .frame_err(a_fe)
  );

  sensor_sync_decoder #(.VSYNC_POL(1'b0), .HREF_POL(1'b0), .LINE_PIXELS(LP), .FRAME_LINES(FL))
  dut_b (
    .pixclk(pixclk), .reset(reset), .enable(enable), .cam_vsync(~vs_pin), .cam_href(~hr_pin),
    .cam_data(d_pin), .sensor_din(b_din), .sensor_state(b_ss), .frame_begin(b_fb),
    .line_begin(b_lb), .frame_state(b_fs), .line_state(b_ls), .pixel_count(b_pc),
    .line_count(b_lc), .frame_count(b_fc), .line_err(b_le), .frame_err(b_fe)
  );

  assign a_o = {a_fs, a_fb, a_ls, a_lb, a_ss, a_din, a_pc, a_lc, a_le, a_fe, a_fc};
  assign b_o = {b_fs, b_fb, b_ls, b_lb, b_ss, b_din, b_pc, b_lc, b_le, b_fe, b_fc};

  int checks = 0;
  int errors = 0;
  int fb_cnt, lb_cnt, ls_cnt, ss_cnt, lb_pc, lb_din;
  int dcnt = 0;
  logic fs_prev;

  // Frame-level scoreboard state.
  bit   mon_en = 1'b0;
  int   frames_seen;
  int   exp_lens[$];
  int   act_lens[$];
  int   exp_bytes[$];
  int   act_bytes[$];
  int   exp_nl, exp_le, exp_fe, exp_fc;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL pass%0d %s: got %0h want %0h", pass_sel, nm, act, exp);
    end
  endtask

  task automatic frame_compare();
    int bad;
    chk("sb_nlines", longint'(act_lens.size()), longint'(exp_lens.size()));
    bad = 0;
    foreach (exp_lens[i]) if (i >= act_lens.size() || act_lens[i] != exp_lens[i]) bad++;
    chk("sb_line_lengths_bad", longint'(bad), 0);
    bad = 0;
    if (act_bytes.size() != exp_bytes.size()) bad++;
    foreach (exp_bytes[i]) if (i >= act_bytes.size() || act_bytes[i] != exp_bytes[i]) bad++;
    chk("sb_bytes_bad", longint'(bad), 0);
    chk("sb_line_count", longint'(s.lc), longint'(exp_nl));
    chk("sb_line_err", longint'(s.le), longint'(exp_le));
    chk("sb_frame_err", longint'(s.fe), longint'(exp_fe));
    chk("sb_frame_count", longint'(s.fc), longint'(exp_fc % 65536));
    act_lens.delete(); act_bytes.delete(); exp_lens.delete(); exp_bytes.delete();
    frames_seen++;
  endtask

  task automatic step();
    @(posedge pixclk);
    #1;
    s = pass_sel ? b_o : a_o;
    if (s.fb) fb_cnt++;
    if (s.lb) begin lb_cnt++; lb_pc = int'(s.pc); lb_din = int'(s.din); end
    if (s.ls) ls_cnt++;
    if (s.ss) ss_cnt++;
    if (mon_en) begin
      if (s.lb) act_lens.push_back(0);
      if (s.ss) begin
        if (act_lens.size() == 0) act_lens.push_back(0);
        act_lens[act_lens.size() - 1] = act_lens[act_lens.size() - 1] + 1;
        act_bytes.push_back(int'(s.din));
      end
      if (fs_prev && !s.fs) frame_compare();
    end
    fs_prev = s.fs;
  endtask

  task automatic cyc(input int v, input int h, input int d);
    vs_pin = (v != 0);
    hr_pin = (h != 0);
    d_pin  = 8'(d);
    step();
  endtask

  task automatic clr_cnt();
    fb_cnt = 0; lb_cnt = 0; ls_cnt = 0; ss_cnt = 0; lb_pc = -1; lb_din = -1;
  endtask

  task automatic do_reset(input int en);
    reset = 1'b1; enable = (en != 0); vs_pin = 1'b0; hr_pin = 1'b0; d_pin = 8'h00;
    step(); step();
    reset = 1'b0;
    clr_cnt();
    fs_prev = 1'b0;
  endtask

  task automatic send_line(input int len, input int gap);
    for (int i = 0; i < len; i++) begin
      cyc(0, 1, dcnt);
      exp_bytes.push_back(dcnt % 256);
      dcnt++;
    end
    exp_lens.push_back(len);
    for (int i = 0; i < gap; i++) cyc(0, 0, 0);
  endtask

  task automatic vs_hi(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0);
  endtask

  task automatic vs_lo(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  vec_t tbl[14];
  out_t e;

  initial begin
    // v h data | fs fb ls lb ss din pc lc le fe fc  (outputs sampled after that row's edge)
    tbl[0]  = '{0, 0, 0,     0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0,     0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0,     0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0,     0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 'hA0,  1, 1, 0, 0, 0, 0,     0, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 'hA1,  1, 0, 1, 1, 1, 'hA0,  1, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 0,     1, 0, 1, 0, 1, 'hA1,  2, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 0,     1, 0, 0, 0, 0, 'hA1,  2, 1, 1, 0, 0};
    tbl[8]  = '{0, 1, 'hB0,  1, 0, 0, 0, 0, 'hA1,  2, 1, 1, 0, 0};
    tbl[9]  = '{1, 0, 0,     1, 0, 1, 1, 1, 'hB0,  1, 1, 1, 0, 0};
    tbl[10] = '{1, 0, 0,     0, 0, 0, 0, 0, 'hB0,  1, 2, 1, 1, 1};
    tbl[11] = '{0, 0, 0,     0, 0, 0, 0, 0, 'hB0,  1, 2, 1, 1, 1};
    tbl[12] = '{0, 0, 0,     1, 1, 0, 0, 0, 'hB0,  0, 0, 0, 0, 1};
    tbl[13] = '{0, 0, 0,     1, 0, 0, 0, 0, 'hB0,  0, 0, 0, 0, 1};

    reset = 1'b1; enable = 1'b0; vs_pin = 1'b0; hr_pin = 1'b0; d_pin = 8'h00; pass_sel = 1'b0;

    for (int p = 0; p < 2; p++) begin
      pass_sel = p[0];

      // Cycle-exact table: short line, truncated line, re-entry into the next frame.
      do_reset(1);
      chk("reset_state", longint'(s), 0);
      for (int i = 0; i < 14; i++) begin
        cyc(tbl[i].v, tbl[i].h, tbl[i].d);
        e = {1'(tbl[i].fs), 1'(tbl[i].fb), 1'(tbl[i].ls), 1'(tbl[i].lb), 1'(tbl[i].ss),
             8'(tbl[i].din), 12'(tbl[i].pc), 12'(tbl[i].lc), 1'(tbl[i].le), 1'(tbl[i].fe),
             16'(tbl[i].fc)};
        chk($sformatf("row%0d", i), longint'(s), longint'(e));
      end

      // Async reset mid-line clears everything without a clock edge.
      cyc(0, 1, 'h33); cyc(0, 1, 'h34); cyc(0, 1, 'h35);
      #3 reset = 1'b1;
      #1 s = pass_sel ? b_o : a_o;
      chk("async_reset", longint'(s), 0);
      step();
      reset = 1'b0;

      // Href already active at frame entry, then a one-cycle href pulse.
      do_reset(1);
      cyc(0, 0, 0); cyc(0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, 1, 'h11);
      for (int i = 0; i < 4; i++) cyc(0, 1, 'h22);
      cyc(0, 0, 0); cyc(0, 0, 0);
      chk("entry_line_begin", longint'(lb_cnt), 0);
      chk("entry_frame_state", longint'(s.fs), 1);
      cyc(0, 1, 'h5A);
      vs_lo(3);
      chk("pulse_line_begin", longint'(lb_cnt), 1);
      chk("pulse_line_state_cycles", longint'(ls_cnt), 1);
      chk("pulse_sensor_state_cycles", longint'(ss_cnt), 1);
      chk("pulse_pixel_count", longint'(lb_pc), 1);
      chk("pulse_din", longint'(lb_din), 'h5A);
      chk("pulse_line_count", longint'(s.lc), 1);
      vs_hi(3);
      chk("pulse_end_frame_state", longint'(s.fs), 0);
      chk("pulse_end_errs", longint'({s.le, s.fe}), 3);
      chk("pulse_end_frame_count", longint'(s.fc), 1);
      vs_lo(2);

      // Enable raised mid-frame, then dropped mid-frame.
      do_reset(0);
      vs_hi(3); vs_lo(2);
      send_line(LP, 2);
      cyc(0, 1, 1); cyc(0, 1, 2);
      enable = 1'b1;
      for (int i = 0; i < LP - 2; i++) cyc(0, 1, 3);
      vs_lo(2);
      send_line(LP, 2); send_line(LP, 2);
      vs_hi(3);
      chk("midstart_no_frame_begin", longint'(fb_cnt), 0);
      chk("midstart_no_sensor_state", longint'(ss_cnt), 0);
      vs_lo(2);
      chk("midstart_frame_begin", longint'(fb_cnt), 1);
      clr_cnt();
      send_line(LP, 2);
      enable = 1'b0;
      for (int l = 1; l < FL; l++) send_line(LP, 2);
      vs_hi(3);
      chk("disable_frame_state", longint'(s.fs), 0);
      chk("disable_line_count", longint'(s.lc), FL);
      chk("disable_errs", longint'({s.le, s.fe}), 0);
      chk("disable_frame_count", longint'(s.fc), 1);
      chk("disable_line_begins", longint'(lb_cnt), FL);
      vs_lo(2);
      clr_cnt();
      for (int l = 0; l < FL; l++) send_line(LP, 2);
      vs_hi(3); vs_lo(2);
      chk("disable_no_frame_begin", longint'(fb_cnt), 0);
      chk("disable_no_sensor_state", longint'(ss_cnt), 0);

      // Randomised frames against the frame-level scoreboard.
      do_reset(1);
      exp_lens.delete(); exp_bytes.delete(); act_lens.delete(); act_bytes.delete();
      exp_fc = 0; frames_seen = 0;
      mon_en = 1'b1;
      vs_lo(2); vs_hi(3); vs_lo(2);
      for (int f = 0; f < 25; f++) begin
        int nl, r, len, le;
        bit tr;
        r  = int'($urandom % 6);
        nl = (r == 0) ? FL - 1 : (r == 1) ? FL + 1 : FL;
        tr = ($urandom % 5) == 0;
        le = 0;
        for (int l = 0; l < nl; l++) begin
          if (tr && l == nl - 1) begin
            len = 1 + int'($urandom % LP);
            send_line(len, 0);
          end else begin
            r   = int'($urandom % 6);
            len = (r == 0) ? 1 : (r == 1) ? LP - 1 : (r == 2) ? LP + 1 : LP;
            send_line(len, 1 + int'($urandom % 2));
          end
          if (len != LP) le = 1;
        end
        exp_nl = nl;
        exp_le = le;
        exp_fe = (nl != FL) ? 1 : 0;
        exp_fc++;
        if (tr) begin
          cyc(1, 1, 'hEE);
          vs_hi(2);
        end else begin
          vs_hi(3);
        end
        vs_lo(2);
      end
      mon_en = 1'b0;
      chk("sb_frames_seen", longint'(frames_seen), 25);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
